// File: rtl/log2_pkg.sv
// Shared types and helpers for the iterative fixed-point log2 unit.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } log2_state_t;

  // Result is {integer part, fraction}.
  function automatic int res_width(input int log_width, input int frac_bits);
    return log_width + frac_bits;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit priority encoder; zero flags an all-zero input.
module prio_enc #(
  parameter int WIDTH     = 8,
  parameter int LOG_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     din,
  output logic [LOG_WIDTH-1:0] idx,
  output logic                 zero
);

  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational (no latch).
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) idx = LOG_WIDTH'(i);
    end
  end

  assign zero = ~|din;

endmodule

// File: rtl/log2_frac.sv
// Sequential fixed-point log2: integer part by priority encode, then one
// fraction bit per cycle by repeated squaring of the normalised mantissa.
module log2_frac
  import log2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4,
  parameter int LOG_WIDTH = $clog2(WIDTH)
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  input  logic [WIDTH-1:0]                            i_din,
  output logic                                        o_valid,
  input  logic                                        i_ready,
  output logic [res_width(LOG_WIDTH, FRAC_BITS)-1:0]  o_dout,
  output logic                                        o_zero
);

  localparam int RW = res_width(LOG_WIDTH, FRAC_BITS);
  localparam int CW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

  log2_state_t          state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     m;
  logic [LOG_WIDTH-1:0] k;
  logic [LOG_WIDTH-1:0] sh;
  logic                 din_zero;
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH-1:0]     m_next;
  logic                 fbit;
  logic                 last;
  logic                 unused_lsbs;

  prio_enc #(
    .WIDTH    (WIDTH),
    .LOG_WIDTH(LOG_WIDTH)
  ) u_enc (
    .din (i_din),
    .idx (k),
    .zero(din_zero)
  );

  assign sh = LOG_WIDTH'(WIDTH - 1) - k;

  // m is Q1.(WIDTH-1) in [1,2), so m*m is in [1,4); the top bit says >= 2.
  assign p           = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, m};
  assign fbit        = p[2*WIDTH-1];
  assign m_next      = fbit ? p[2*WIDTH-1:WIDTH] : p[2*WIDTH-2:WIDTH-1];
  assign unused_lsbs = ^p[WIDTH-2:0];
  assign last        = (int'(cnt) == FRAC_BITS - 1);

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      o_dout <= '0;
      o_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            cnt <= '0;
            if (din_zero) begin
              m      <= '0;
              o_dout <= '0;
              o_zero <= 1'b1;
              state  <= DONE;
            end else begin
              m      <= i_din << sh;
              o_dout <= RW'(k);
              o_zero <= 1'b0;
              state  <= (FRAC_BITS == 0) ? DONE : ITER;
            end
          end
        end
        ITER: begin
          // Integer part drifts up to the MSBs as fraction bits shift in below.
          m      <= m_next;
          o_dout <= (o_dout << 1) | RW'(fbit);
          cnt    <= cnt + CW'(1);
          if (last) state <= DONE;
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_frac.sv
// Self-checking bench for log2_frac (WIDTH=8, FRAC_BITS=4): vector table,
// backpressure, mid-operation reset and a full operand sweep via a scoreboard.
module tb_log2_frac;

  localparam int WIDTH     = 8;
  localparam int FRAC_BITS = 4;
  localparam int RW        = 7;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [7:0]    i_din   = '0;
  logic          o_ready;
  logic          o_valid;
  logic          o_zero;
  logic [RW-1:0] o_dout;

  always #5 i_clk = ~i_clk;

  log2_frac #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_din  (i_din),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_dout (o_dout),
    .o_zero (o_zero)
  );

  typedef struct {
    logic [RW-1:0] dout;
    logic          zero;
  } exp_t;

  typedef struct {
    logic [7:0]    din;
    logic [RW-1:0] dout;
    logic          zero;
    int            lat;
  } vec_t;

  exp_t q[$];
  exp_t pend_exp;
  exp_t popped;
  int   checks   = 0;
  int   failures = 0;
  int   results  = 0;
  int   accepts  = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor-log2 integer part, then four squarings of a Q1.7 mantissa.
  function automatic exp_t ref_model(input logic [7:0] x);
    exp_t r;
    int   k;
    int   mm;
    int   prod;
    r.dout = '0;
    r.zero = (x == 8'd0);
    if (!r.zero) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (x[i]) k = i;
      mm = int'(x) << (7 - k);
      r.dout = RW'(k * 16);
      for (int j = 0; j < 4; j++) begin
        prod = mm * mm;
        if (prod >= 32768) begin
          r.dout = r.dout | RW'(1 << (3 - j));
          mm = prod >> 8;
        end else begin
          mm = prod >> 7;
        end
      end
    end
    return r;
  endfunction

  // Monitor: hold-under-backpressure, accept -> push, handshake -> pop/compare.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [RW-1:0] pd = '0;
  logic          pz = 1'b0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", o_valid, 1);
        check("hold_dout", o_dout, pd);
        check("hold_zero", o_zero, pz);
      end
      if (i_valid && o_ready) begin
        q.push_back(pend_exp);
        accepts++;
      end
      if (o_valid && i_ready) begin
        results++;
        check("result_pending", (q.size() > 0), 1);
        if (q.size() > 0) begin
          popped = q.pop_front();
          check("dout", o_dout, popped.dout);
          check("zero", o_zero, popped.zero);
        end
      end
      pv = o_valid;
      pr = i_ready;
      pd = o_dout;
      pz = o_zero;
    end
  end

  always @(posedge i_clk) begin
    if (rand_rdy) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  // Returns 1 ns after the accept edge E0.
  task automatic send(input logic [7:0] d, input exp_t e);
    int n;
    n = 0;
    @(posedge i_clk);
    #1;
    pend_exp = e;
    i_din    = d;
    i_valid  = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("accept_timeout", (n < 200), 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_din   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("idle_timeout", (n < 200), 1);
  endtask

  initial begin
    vec_t tbl[7];
    exp_t e;
    int   lat;
    int   n;
    int   res_base;
    int   acc_base;

    tbl[0] = '{8'h03, 7'h19, 1'b0, 4};
    tbl[1] = '{8'h0F, 7'h3E, 1'b0, 4};
    tbl[2] = '{8'h80, 7'h70, 1'b0, 4};
    tbl[3] = '{8'h01, 7'h00, 1'b0, 4};
    tbl[4] = '{8'h00, 7'h00, 1'b1, 0};
    tbl[5] = '{8'hFF, 7'h7F, 1'b0, 4};
    tbl[6] = '{8'h05, 7'h25, 1'b0, 4};

    #12;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_dout", o_dout, 0);
    check("rst_zero", o_zero, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;

    // Table vectors: value via scoreboard, latency counted from E0.
    for (int i = 0; i < 7; i++) begin
      e.dout = tbl[i].dout;
      e.zero = tbl[i].zero;
      send(tbl[i].din, e);
      lat = 0;
      while (!o_valid && lat < 50) begin
        @(posedge i_clk);
        #1;
        lat++;
      end
      check("latency", lat, tbl[i].lat);
      wait_idle();
    end

    // Backpressure: result held, ready low, new operands ignored.
    i_ready = 1'b0;
    e.dout  = 7'h3E;
    e.zero  = 1'b0;
    send(8'h0F, e);
    n = 0;
    while (!o_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("bp_valid_timeout", (n < 50), 1);
    repeat (5) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b1;
      i_din   = 8'($urandom_range(1, 255));
      @(negedge i_clk);
      check("bp_ready", o_ready, 0);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge i_clk);
    check("bp_no_extra", o_valid, 0);
    check("bp_queue", q.size(), 0);

    // Reset mid-ITER discards the operation.
    e.dout = 7'h19;
    e.zero = 1'b0;
    send(8'h03, e);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_dout", o_dout, 0);
    check("mid_rst_zero", o_zero, 0);
    q.delete();
    #10;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    check("post_rst_valid", o_valid, 0);
    send(8'h03, e);
    wait_idle();
    check("post_rst_queue", q.size(), 0);

    // Sweep of every operand with random consumer readiness.
    res_base = results;
    acc_base = accepts;
    rand_rdy = 1'b1;
    for (int x = 0; x < 256; x++) send(8'(x), ref_model(8'(x)));
    n = 0;
    while ((q.size() != 0 || o_valid) && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check("sweep_drain", (n < 2000), 1);
    rand_rdy = 1'b0;
    check("sweep_accepts", accepts - acc_base, 256);
    check("sweep_results", results - res_base, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
